// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one external memory bus between the instruction-fetch
//               port and the data-access port. Grants one requester at a
//               time, registers the bus command, waits for the active-low
//               acknowledge, and returns registered read data with a
//               one-cycle valid pulse plus combinational stalls.
// Options     : `define MEM_BUS_ARB_TIMEOUT_EN builds an abort counter that
//               ends a transaction after TIMEOUT_CYCLES cycles without ack.
// Revision    : 1.0 - initial release
//============================================================================
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_x,
   // fetch port
   input  logic        i_iReq,
   input  logic [31:0] i_iAddr,
   output logic [31:0] o_iData,
   output logic        o_iValid,
   output logic        o_iStall,
   // data port
   input  logic        i_dReq,
   input  logic        i_dWrite,
   input  logic [1:0]  i_dSize,
   input  logic [31:0] i_dAddr,
   input  logic [31:0] i_dWData,
   output logic [31:0] o_dRData,
   output logic        o_dValid,
   output logic        o_dStall,
   // memory bus
   output logic        o_memReq,
   output logic        o_memWrite,
   output logic [1:0]  o_memSize,
   output logic [31:0] o_memAddr,
   output logic [31:0] o_memWData,
   input  logic [31:0] i_memRData,
   input  logic        i_ack_n,
   // abort reporting
   output logic        o_busErr,
   output logic        o_errIsData
);

   localparam logic [1:0] c_size_word = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IBUS = 2'd1,
      ST_DBUS = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_last_grant_d;   // 1 = last finished transaction was data
   logic   w_grant_i;
   logic   w_grant_d;
   logic   w_done;
   logic   w_abort;
   logic   w_ack;
   logic   w_i_elig;
   logic   w_d_elig;

   // A zero-length timeout is meaningless; reject it at elaboration.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   assign w_ack = ~i_ack_n;

   // A port stalls while it asks and has neither its data nor its abort yet.
   assign o_iStall = i_iReq & ~o_iValid & ~(o_busErr & ~o_errIsData);
   assign o_dStall = i_dReq & ~o_dValid & ~(o_busErr &  o_errIsData);

   // During the valid/abort cycle the request line still carries the request
   // that just finished, so only a stalled port is a genuinely new request.
   assign w_i_elig = o_iStall;
   assign w_d_elig = o_dStall;

   // State register.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Arbitration and next-state: data wins unless data went last.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_d_elig && (!w_i_elig || !r_last_grant_d)) begin
               w_grant_d = 1'b1;
            end else if (w_i_elig) begin
               w_grant_i = 1'b1;
            end
         end
         ST_IBUS: begin
            if (w_ack) begin
               w_done    = 1'b1;
               w_grant_d = w_d_elig;
            end
         end
         ST_DBUS: begin
            if (w_ack) begin
               w_done    = 1'b1;
               w_grant_i = w_i_elig;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_grant_d) begin
         w_state_nxt = ST_DBUS;
      end else if (w_grant_i) begin
         w_state_nxt = ST_IBUS;
      end else if (w_done || w_abort) begin
         w_state_nxt = ST_IDLE;
      end
   end

   // Bus command registers: loaded on grant, held until the transaction ends.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         o_memReq   <= 1'b0;
         o_memWrite <= 1'b0;
         o_memSize  <= 2'b00;
         o_memAddr  <= 32'h0;
         o_memWData <= 32'h0;
      end else begin
         o_memReq <= (w_state_nxt != ST_IDLE);
         if (w_grant_d) begin
            o_memWrite <= i_dWrite;
            o_memSize  <= i_dSize;
            o_memAddr  <= i_dAddr;
            o_memWData <= i_dWData;
         end else if (w_grant_i) begin
            o_memWrite <= 1'b0;
            o_memSize  <= c_size_word;
            o_memAddr  <= i_iAddr;
         end
      end
   end

   // Read data capture and valid pulses; a withdrawn request gets no pulse.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         o_iData  <= 32'h0;
         o_dRData <= 32'h0;
         o_iValid <= 1'b0;
         o_dValid <= 1'b0;
      end else begin
         o_iValid <= w_done && (r_state == ST_IBUS) && i_iReq;
         o_dValid <= w_done && (r_state == ST_DBUS) && i_dReq;
         if (w_done && (r_state == ST_IBUS)) begin
            o_iData <= i_memRData;
         end
         if (w_done && (r_state == ST_DBUS)) begin
            o_dRData <= i_memRData;
         end
      end
   end

   // Remember who finished last for the alternation rule.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_last_grant_d <= 1'b0;
      end else if (w_done || w_abort) begin
         r_last_grant_d <= (r_state == ST_DBUS);
      end
   end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
   localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [c_cnt_w-1:0] r_to_cnt;

   assign w_abort = (r_state != ST_IDLE) && !w_ack &&
                    (r_to_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

   // Cycles spent waiting for ack in the current transaction.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_to_cnt <= '0;
      end else if (w_grant_i || w_grant_d) begin
         r_to_cnt <= '0;
      end else if ((r_state != ST_IDLE) && !w_ack) begin
         r_to_cnt <= r_to_cnt + c_cnt_w'(1);
      end
   end

   // One-cycle abort report tagged with the owning port.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         o_busErr    <= 1'b0;
         o_errIsData <= 1'b0;
      end else begin
         o_busErr    <= w_abort;
         o_errIsData <= w_abort && (r_state == ST_DBUS);
      end
   end
`else
   assign w_abort     = 1'b0;
   assign o_busErr    = 1'b0;
   assign o_errIsData = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter: directed scenarios
//               followed by a randomized run against a transaction-level
//               reference model of the arbitration rules.
// Options     : MEM_BUS_ARB_TIMEOUT_EN selects the abort or wait-forever
//               expectation in the timeout scenario.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_bus_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset_x = 1'b0;
   logic        i_iReq = 1'b0;
   logic [31:0] i_iAddr = 32'h0;
   logic [31:0] o_iData;
   logic        o_iValid;
   logic        o_iStall;
   logic        i_dReq = 1'b0;
   logic        i_dWrite = 1'b0;
   logic [1:0]  i_dSize = 2'b00;
   logic [31:0] i_dAddr = 32'h0;
   logic [31:0] i_dWData = 32'h0;
   logic [31:0] o_dRData;
   logic        o_dValid;
   logic        o_dStall;
   logic        o_memReq;
   logic        o_memWrite;
   logic [1:0]  o_memSize;
   logic [31:0] o_memAddr;
   logic [31:0] o_memWData;
   logic [31:0] i_memRData = 32'h0;
   logic        i_ack_n = 1'b1;
   logic        o_busErr;
   logic        o_errIsData;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_owner;   // 0 none, 1 fetch, 2 data
   int          m_wait;    // wait cycles left before memory acks
   logic        m_last_d;
   logic        exp_iv, exp_dv, n_iv, n_dv, e_i, e_d;
   logic        i_retire, d_retire;
   logic [31:0] exp_idata, exp_ddata;
   logic [31:0] g_addr, g_wdata;
   logic        g_write;
   logic [1:0]  g_size;
   int          n;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset_x    (reset_x),
      .i_iReq     (i_iReq),
      .i_iAddr    (i_iAddr),
      .o_iData    (o_iData),
      .o_iValid   (o_iValid),
      .o_iStall   (o_iStall),
      .i_dReq     (i_dReq),
      .i_dWrite   (i_dWrite),
      .i_dSize    (i_dSize),
      .i_dAddr    (i_dAddr),
      .i_dWData   (i_dWData),
      .o_dRData   (o_dRData),
      .o_dValid   (o_dValid),
      .o_dStall   (o_dStall),
      .o_memReq   (o_memReq),
      .o_memWrite (o_memWrite),
      .o_memSize  (o_memSize),
      .o_memAddr  (o_memAddr),
      .o_memWData (o_memWData),
      .i_memRData (i_memRData),
      .i_ack_n    (i_ack_n),
      .o_busErr   (o_busErr),
      .o_errIsData(o_errIsData)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_memreq", o_memReq, 1'b0);
      chk1("rst_memwrite", o_memWrite, 1'b0);
      chk("rst_memsize", 32'(o_memSize), 32'h0);
      chk("rst_memaddr", o_memAddr, 32'h0);
      chk("rst_memwdata", o_memWData, 32'h0);
      chk("rst_idata", o_iData, 32'h0);
      chk("rst_drdata", o_dRData, 32'h0);
      chk1("rst_ivalid", o_iValid, 1'b0);
      chk1("rst_dvalid", o_dValid, 1'b0);
      chk1("rst_istall", o_iStall, 1'b0);
      chk1("rst_dstall", o_dStall, 1'b0);
      chk1("rst_buserr", o_busErr, 1'b0);
      chk1("rst_erridata", o_errIsData, 1'b0);
      reset_x = 1'b1;
      tick();

      // ---------------- single fetch, minimum latency ----------------
      i_iReq = 1'b1; i_iAddr = 32'h0000_0100;
      tick();
      chk1("f1_memreq", o_memReq, 1'b1);
      chk("f1_memaddr", o_memAddr, 32'h0000_0100);
      chk1("f1_memwrite", o_memWrite, 1'b0);
      chk("f1_memsize", 32'(o_memSize), 32'h2);
      chk1("f1_istall_wait", o_iStall, 1'b1);
      i_ack_n = 1'b0; i_memRData = 32'h0000_0013;
      tick();
      chk1("f1_ivalid", o_iValid, 1'b1);
      chk("f1_idata", o_iData, 32'h0000_0013);
      chk1("f1_istall_done", o_iStall, 1'b0);
      chk1("f1_memreq_off", o_memReq, 1'b0);
      i_iReq = 1'b0; i_ack_n = 1'b1;
      tick();
      chk1("f1_ivalid_pulse", o_iValid, 1'b0);

      // ---------------- dual request from idle ----------------
      i_iReq = 1'b1; i_iAddr = 32'h0000_0200;
      i_dReq = 1'b1; i_dWrite = 1'b0; i_dSize = 2'b10; i_dAddr = 32'h8000_0000;
      tick();
      chk("dual_first_addr", o_memAddr, 32'h8000_0000);
      chk("dual_first_size", 32'(o_memSize), 32'h2);
      chk1("dual_first_write", o_memWrite, 1'b0);
      chk1("dual_istall", o_iStall, 1'b1);
      chk1("dual_dstall", o_dStall, 1'b1);
      i_ack_n = 1'b0; i_memRData = 32'hCAFE_0001;
      tick();
      chk1("dual_dvalid", o_dValid, 1'b1);
      chk("dual_drdata", o_dRData, 32'hCAFE_0001);
      chk1("dual_b2b_memreq", o_memReq, 1'b1);
      chk("dual_b2b_addr", o_memAddr, 32'h0000_0200);
      chk1("dual_istall_hold", o_iStall, 1'b1);
      chk1("dual_dstall_done", o_dStall, 1'b0);
      i_dReq = 1'b0; i_memRData = 32'h1357_9BDF;
      tick();
      chk1("dual_ivalid", o_iValid, 1'b1);
      chk("dual_idata", o_iData, 32'h1357_9BDF);
      chk1("dual_dvalid_pulse", o_dValid, 1'b0);
      chk1("dual_memreq_off", o_memReq, 1'b0);
      i_iReq = 1'b0; i_ack_n = 1'b1;
      tick();

      // ---------------- fairness under continuous dual requests ----------------
      i_iReq = 1'b1; i_iAddr = 32'h0000_0300;
      i_dReq = 1'b1; i_dWrite = 1'b0; i_dSize = 2'b10; i_dAddr = 32'h0000_0400;
      i_ack_n = 1'b0;
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         tick();
         if (o_memReq) begin
            chk("fair_grant", o_memAddr, (n % 2 == 0) ? 32'h0000_0400 : 32'h0000_0300);
            n++;
            if (n == 6) begin
               i_iReq = 1'b0;
               i_dReq = 1'b0;
            end
         end
      end
      chk("fair_count", 32'(n), 32'd6);
      tick();
      i_ack_n = 1'b1;
      tick();
      tick();

      // ---------------- flush: withdrawn fetch ----------------
      i_iReq = 1'b1; i_iAddr = 32'h0000_0500;
      tick();
      chk1("flush_memreq", o_memReq, 1'b1);
      chk("flush_addr", o_memAddr, 32'h0000_0500);
      i_iReq = 1'b0; i_ack_n = 1'b0;
      tick();
      chk1("flush_no_valid", o_iValid, 1'b0);
      chk1("flush_memreq_off", o_memReq, 1'b0);
      chk1("flush_istall", o_iStall, 1'b0);
      i_ack_n = 1'b1;
      tick();
      chk1("flush_no_valid2", o_iValid, 1'b0);

      // ---------------- byte store with 3 wait cycles ----------------
      i_dReq = 1'b1; i_dWrite = 1'b1; i_dSize = 2'b00;
      i_dAddr = 32'h8000_0003; i_dWData = 32'h0000_00AB;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk1("st_memreq", o_memReq, 1'b1);
         chk1("st_memwrite", o_memWrite, 1'b1);
         chk("st_addr", o_memAddr, 32'h8000_0003);
         chk("st_wdata", o_memWData, 32'h0000_00AB);
         chk("st_size", 32'(o_memSize), 32'h0);
         chk1("st_dvalid_early", o_dValid, 1'b0);
         chk1("st_dstall", o_dStall, 1'b1);
         if (k == 1) begin
            i_dAddr = 32'h1111_1111;
            i_dWData = 32'h5A5A_5A5A;
         end
         if (k == 3) i_ack_n = 1'b0;
      end
      tick();
      chk1("st_dvalid", o_dValid, 1'b1);
      chk1("st_dstall_done", o_dStall, 1'b0);
      chk1("st_memreq_off", o_memReq, 1'b0);
      i_dReq = 1'b0; i_ack_n = 1'b1;
      tick();
      chk1("st_dvalid_pulse", o_dValid, 1'b0);

      // ---------------- ack never arrives ----------------
      i_dReq = 1'b1; i_dWrite = 1'b0; i_dSize = 2'b10; i_dAddr = 32'h8000_0020;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         tick();
         chk1("to_memreq", o_memReq, 1'b1);
         chk1("to_no_err", o_busErr, 1'b0);
         chk1("to_dstall", o_dStall, 1'b1);
      end
      tick();
      chk1("to_buserr", o_busErr, 1'b1);
      chk1("to_errisdata", o_errIsData, 1'b1);
      chk1("to_memreq_off", o_memReq, 1'b0);
      chk1("to_dstall_off", o_dStall, 1'b0);
      chk1("to_no_dvalid", o_dValid, 1'b0);
      i_dReq = 1'b0;
      tick();
      chk1("to_buserr_pulse", o_busErr, 1'b0);
      chk1("to_idle", o_memReq, 1'b0);
`else
      for (int k = 0; k < 8; k++) begin
         tick();
         chk1("to_memreq_hold", o_memReq, 1'b1);
         chk1("to_no_err", o_busErr, 1'b0);
      end
      i_ack_n = 1'b0; i_memRData = 32'h0BAD_F00D;
      tick();
      chk1("to_late_dvalid", o_dValid, 1'b1);
      chk("to_late_data", o_dRData, 32'h0BAD_F00D);
      i_dReq = 1'b0; i_ack_n = 1'b1;
      tick();
`endif

      // ---------------- async reset mid-transaction ----------------
      i_dReq = 1'b1; i_dWrite = 1'b0; i_dSize = 2'b10; i_dAddr = 32'h8000_0010;
      tick();
      chk1("rmid_memreq", o_memReq, 1'b1);
      #2;
      reset_x = 1'b0;
      #1;
      chk1("rmid_memreq_drop", o_memReq, 1'b0);
      chk("rmid_addr_clr", o_memAddr, 32'h0);
      i_dReq = 1'b0;
      reset_x = 1'b1;
      tick();
      chk1("rmid_no_valid", o_dValid, 1'b0);
      chk1("rmid_idle", o_memReq, 1'b0);

      // ---------------- randomized run against the reference model ----------------
      m_owner = 0; m_wait = 0; m_last_d = 1'b0;
      exp_iv = 1'b0; exp_dv = 1'b0; i_retire = 1'b0; d_retire = 1'b0;
      exp_idata = 32'h0; exp_ddata = 32'h0;
      g_addr = 32'h0; g_wdata = 32'h0; g_write = 1'b0; g_size = 2'b00;
      for (int c = 0; c < 400; c++) begin
         chk1("rnd_memreq", o_memReq, m_owner != 0);
         chk1("rnd_ivalid", o_iValid, exp_iv);
         chk1("rnd_dvalid", o_dValid, exp_dv);
         chk1("rnd_buserr", o_busErr, 1'b0);
         if (exp_iv) chk("rnd_idata", o_iData, exp_idata);
         if (exp_dv) chk("rnd_ddata", o_dRData, exp_ddata);
         if (m_owner != 0) begin
            chk("rnd_addr", o_memAddr, g_addr);
            chk1("rnd_write", o_memWrite, g_write);
            chk("rnd_size", 32'(o_memSize), 32'(g_size));
            if (g_write) chk("rnd_wdata", o_memWData, g_wdata);
         end
         // requesters: hold until valid, retire the cycle after it
         if (i_retire) i_iReq = 1'b0;
         if (d_retire) i_dReq = 1'b0;
         i_retire = exp_iv;
         d_retire = exp_dv;
         if (!i_iReq && $urandom_range(0, 2) == 0) begin
            i_iReq  = 1'b1;
            i_iAddr = {16'h0000, 16'($urandom) & 16'hFFFC};
         end
         if (!i_dReq && $urandom_range(0, 2) == 0) begin
            i_dReq   = 1'b1;
            i_dWrite = 1'($urandom_range(0, 1));
            i_dSize  = 2'($urandom_range(0, 2));
            i_dAddr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            i_dWData = $urandom;
         end
         // memory: ack after the chosen wait, random noise when idle
         if (m_owner != 0) i_ack_n = (m_wait != 0);
         else              i_ack_n = ($urandom_range(0, 3) != 0);
         i_memRData = $urandom;
         #1;
         chk1("rnd_istall", o_iStall, i_iReq & ~exp_iv);
         chk1("rnd_dstall", o_dStall, i_dReq & ~exp_dv);
         // model advance across the coming edge
         e_i = i_iReq & ~exp_iv;
         e_d = i_dReq & ~exp_dv;
         n_iv = 1'b0;
         n_dv = 1'b0;
         if (m_owner != 0) begin
            if (!i_ack_n) begin
               if (m_owner == 1) begin
                  n_iv = i_iReq; exp_idata = i_memRData; m_last_d = 1'b0; e_i = 1'b0;
               end else begin
                  n_dv = i_dReq; exp_ddata = i_memRData; m_last_d = 1'b1; e_d = 1'b0;
               end
               m_owner = 0;
            end else begin
               m_wait--;
            end
         end
         if (m_owner == 0 && (e_i || e_d)) begin
            if (e_i && e_d) m_owner = m_last_d ? 1 : 2;
            else            m_owner = e_d ? 2 : 1;
            m_wait = int'($urandom_range(0, 3));
            if (m_owner == 2) begin
               g_addr = i_dAddr; g_write = i_dWrite; g_size = i_dSize; g_wdata = i_dWData;
            end else begin
               g_addr = i_iAddr; g_write = 1'b0; g_size = 2'b10;
            end
         end
         exp_iv = n_iv;
         exp_dv = n_dv;
         @(posedge clk);
         #1;
      end

      i_iReq = 1'b0;
      i_dReq = 1'b0;
      i_ack_n = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between the pipeline's instruction-fetch port (F stage) and data-access port (M stage).
- Grants one requester at a time, registers address/control for the transaction, and waits for the active-low memory acknowledge.
- Returns read data with a one-cycle valid pulse and drives per-port stall signals to the hazard unit.
- Sits between the datapath/controller and the memory pins, replacing separate IAD/DAD buses in a single-port memory system.

Parameters:
- TIMEOUT_CYCLES, 16, cycles a granted transaction may wait for ack before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_x  in  1  asynchronous active-low reset
- i_iReq  in  1  fetch request; held until o_iValid or o_busErr
- i_iAddr  in  32  fetch address
- o_iData  out  32  fetched instruction, registered
- o_iValid  out  1  one-cycle pulse, o_iData valid
- o_iStall  out  1  fetch stall to hazard unit
- i_dReq  in  1  data request; held until o_dValid or o_busErr
- i_dWrite  in  1  1 = store
- i_dSize  in  2  access size (00 byte, 01 half, 10 word)
- i_dAddr  in  32  data address
- i_dWData  in  32  store data
- o_dRData  out  32  load data, registered
- o_dValid  out  1  one-cycle pulse, data transaction done
- o_dStall  out  1  data stall to hazard unit
- o_memReq  out  1  bus request (MREQ)
- o_memWrite  out  1  bus write (WRITE)
- o_memSize  out  2  bus size (SIZE)
- o_memAddr  out  32  bus address
- o_memWData  out  32  bus write data
- i_memRData  in  32  bus read data
- i_ack_n  in  1  active-low acknowledge
- o_busErr  out  1  one-cycle timeout-abort pulse
- o_errIsData  out  1  abort belonged to the data port; valid with o_busErr

Behaviour:
- Reset (async, reset_x=0): state IDLE; all outputs 0; registered data 0; lastGrant=instruction.
- States:
  - IDLE: no transaction in flight.
  - IBUS: fetch transaction in flight.
  - DBUS: data transaction in flight.
- Grant is made in IDLE, or on the ack edge that ends a transaction.
- Arbitration:
  - Data port wins over the fetch port.
  - Exception: if lastGrant=data and i_iReq=1, the fetch port wins. Continuous dual requests therefore alternate D,I,D,I.
- On the grant edge: latch the address; for data also latch write, size and wdata. For fetch, o_memWrite=0 and o_memSize=10.
- o_memReq=1 throughout IBUS/DBUS; memory-side outputs stay stable from grant until the ack edge.
- Ack: i_ack_n is sampled low at a rising edge while in IBUS/DBUS. On that edge:
  - capture i_memRData into o_iData/o_dRData (captured for stores too, value don't-care);
  - pulse the matching valid for one cycle;
  - update lastGrant;
  - go to IDLE, or directly grant the other pending request (back-to-back, no idle bubble).
- Minimum latency: request in IDLE at cycle 0 → o_memReq at cycle 1 → ack low in cycle 1 → valid at cycle 2.
- i_ack_n low while in IDLE is ignored.
- Stall: o_iStall = i_iReq & ~o_iValid & ~(o_busErr & ~o_errIsData); o_dStall is the same form for the data port. Both are combinational.
- Request withdrawn mid-transaction (flush): the bus transaction still completes, the valid pulse is suppressed, and stores still occur.
- Simultaneous new request and ack for the same port: the new request is considered for the next grant.
- Reset asserted mid-transaction: o_memReq drops immediately; no valid is issued.

Optional Feature:
- Macro MEM_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and increments each cycle in IBUS/DBUS without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack, the next edge aborts: o_memReq deasserts, o_busErr pulses one cycle, o_errIsData identifies the port, no valid is issued, and the state goes to IDLE (arbitration proceeds as after an ack).
- Undefined: waits indefinitely; o_busErr and o_errIsData are tied to 0; no counter is built.

Test Plan:
- Single fetch: i_iReq=1, i_iAddr=0x0000_0100; ack_n low one cycle after memReq, i_memRData=0x0000_0013 → o_memAddr=0x100, o_iValid pulses at cycle 2, o_iData=0x13, o_iStall low in that cycle.
- Dual request from IDLE: fetch 0x200 and load word 0x8000_0000 → data granted first (o_memSize=10, o_memWrite=0); fetch granted back-to-back on the ack edge; o_iStall stays high until its valid.
- Store: i_dWrite=1, size=00, addr 0x8000_0003, wdata 0xAB; memory inserts 3 wait cycles → o_memWrite, o_memAddr and o_memWData stable for 4 cycles; o_dValid pulses once.
- Fairness: both ports request continuously for 6 transactions → grant order D,I,D,I,D,I.
- Flush: drop i_iReq during IBUS → transaction completes, o_iValid stays 0; then async reset_x low mid-DBUS → o_memReq=0 immediately.
- Timeout (macro defined, TIMEOUT_CYCLES=4): data read, ack never asserted → after 4 cycles o_busErr=1 and o_errIsData=1 for one cycle, o_dStall drops, o_memReq=0. With the macro undefined: o_memReq stays high.
